// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module div_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] SBC,
  input  logic [WIDTH-1:0] SC,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DZ, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // The stored remainder is always below the divisor, so the shifted value is
  // below twice the divisor: the borrow bit of the difference is the compare.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_nxt   = {r_dvd[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (start) begin
            r_dvd  <= SBC;
            r_dvs  <= SC;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
            r_busy <= 1'b1;
            if (SC == '0) begin
              r_state <= S_DZ;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= CW'(WIDTH);
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_q     <= w_q_nxt;
            r_r     <= w_rem_nxt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DZ: begin
          // Zero divisor: the dividend register still holds SBC untouched.
          r_q     <= '1;
          r_r     <= r_dvd;
          r_dbz   <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Q    = r_q;
  assign R    = r_r;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq at WIDTH 8 and 16
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, q8, r8;
  logic        bz8, dn8, dz8;
  logic        s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, q16, r16;
  logic        bz16, dn16, dz16;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_q [2];

  always #5 clk = ~clk;

  div_seq #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .SBC(a8), .SC(b8),
    .busy(bz8), .done(dn8), .Q(q8), .R(r8), .dbz(dz8)
  );

  div_seq #(.WIDTH(16)) u_div16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .SBC(a16), .SC(b16),
    .busy(bz16), .done(dn16), .Q(q16), .R(r16), .dbz(dz16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input logic st, input logic [31:0] a, input logic [31:0] b);
    if (w) begin
      s16 = st; a16 = a[15:0]; b16 = b[15:0];
    end else begin
      s8 = st; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic logic [31:0] rd_q(input bit w);
    return w ? {16'd0, q16} : {24'd0, q8};
  endfunction
  function automatic logic [31:0] rd_r(input bit w);
    return w ? {16'd0, r16} : {24'd0, r8};
  endfunction
  function automatic logic rd_done(input bit w);
    return w ? dn16 : dn8;
  endfunction
  function automatic logic rd_busy(input bit w);
    return w ? bz16 : bz8;
  endfunction
  function automatic logic rd_dbz(input bit w);
    return w ? dz16 : dz8;
  endfunction

  // One operation: start is driven now and accepted at the next rising edge.
  // inj > 0 pulses a stray start with 9/1 in that cycle; abort_at > 0 resets there.
  // Returns at the falling edge inside the done cycle so the next call is back-to-back.
  task automatic op(input bit w, input logic [31:0] a, input logic [31:0] b,
                    input int inj, input int abort_at, input string tag);
    logic [31:0] mask, eq, er;
    logic        edz;
    int          elat, n, extra;
    bit          seen;
    mask = w ? 32'hFFFF : 32'hFF;
    if (b == 0) begin
      eq = mask; er = a; edz = 1'b1; elat = 1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; elat = w ? 16 : 8;
    end
    drive(w, 1'b1, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, $urandom & mask, $urandom & mask);
    n = 0;
    seen = 0;
    while (!seen && n < 60) begin
      @(posedge clk); n++; #1;
      if (inj > 0 && n == inj) drive(w, 1'b1, 9, 1);
      if (inj > 0 && n == inj + 1) drive(w, 1'b0, 9, 1);
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_busy"}, 32'(rd_busy(w)), 0);
        chk({tag, ".rst_done"}, 32'(rd_done(w)), 0);
        chk({tag, ".rst_q"}, rd_q(w), 0);
        chk({tag, ".rst_r"}, rd_r(w), 0);
        chk({tag, ".rst_dbz"}, 32'(rd_dbz(w)), 0);
        prev_q[0] = 0;
        prev_q[1] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin
          @(negedge clk);
          if (rd_done(w)) extra++;
        end
        chk({tag, ".no_done_after_rst"}, extra, 0);
        return;
      end
      @(negedge clk);
      if (n == 1 && elat > 1) begin
        chk({tag, ".busy"}, 32'(rd_busy(w)), 1);
        chk({tag, ".q_hold"}, rd_q(w), prev_q[int'(w)]);
      end
      seen = rd_done(w);
    end
    chk({tag, ".latency"}, n, elat);
    chk({tag, ".q"}, rd_q(w), eq);
    chk({tag, ".r"}, rd_r(w), er);
    chk({tag, ".dbz"}, 32'(rd_dbz(w)), 32'(edz));
    prev_q[int'(w)] = eq;
    if (inj > 0) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (rd_done(w)) extra++;
      end
      chk({tag, ".single_done"}, extra, 0);
    end
  endtask

  int          b2b_a [6] = '{243, 100, 255, 255, 50, 231};
  int          b2b_b [6] = '{3, 26, 9, 255, 91, 6};
  logic [31:0] ra, rb;
  bit          rw;

  initial begin
    prev_q[0] = 0;
    prev_q[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", 32'(bz8), 0);
    chk("reset.done", 32'(dn8), 0);
    chk("reset.q", 32'(q8), 0);
    chk("reset.r", 32'(r8), 0);
    chk("reset.dbz", 32'(dz8), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) op(0, b2b_a[i], b2b_b[i], 0, 0, "b2b");
    repeat (2) @(negedge clk);

    op(0, 77, 0, 0, 0, "dbz");
    op(0, 10, 3, 0, 0, "after_dbz");
    repeat (2) @(negedge clk);

    op(0, 200, 7, 3, 0, "ignored_start");
    op(0, 243, 3, 0, 4, "abort");
    @(negedge clk);
    op(0, 100, 26, 0, 0, "after_abort");
    repeat (2) @(negedge clk);

    op(1, 65535, 7, 0, 0, "w16_a");
    op(1, 1000, 1000, 0, 0, "w16_b");
    repeat (2) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = $urandom & (rw ? 32'hFFFF : 32'hFF);
      rb = ($urandom_range(0, 6) == 0) ? 32'd0 : ($urandom & (rw ? 32'hFFFF : 32'hFF));
      op(rw, ra, rb, 0, 0, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
